// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: carry chain cut into STAGES segments, one register per segment, valid/ready flow.
// Optional saturation on the final stage when ADDSUB_SAT_EN is defined (adds the Sat port).
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             D,
  input  logic             Cin,
  input  logic             Si,
`ifdef ADDSUB_SAT_EN
  input  logic             Sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             So,
  output logic             Z,
  output logic             N
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int SW   = SEG + 1;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic en;

  // *_i: what stage k sees this cycle; *_q: what stage k registered
  logic [WIDTH-1:0] a_i  [STAGES];
  logic [WIDTH-1:0] bx_i [STAGES];
  logic [WIDTH-1:0] s_i  [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_i  [STAGES];
  logic             c_nx [STAGES];
  logic             d_i  [STAGES];
  logic             si_i [STAGES];
  logic             v_i  [STAGES];

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             d_q   [STAGES];
  logic             si_q  [STAGES];
  logic             vld_q [STAGES];
`ifdef ADDSUB_SAT_EN
  logic             sat_i [STAGES];
  logic             sat_q [STAGES];
`endif

  logic [SEG:0]     part;
  logic             cmsb;
  logic             ovf;
  logic             so_nx;
  logic [WIDTH-1:0] res;

  logic [WIDTH-1:0] s_out;
  logic             cout_q, v_q, so_q, z_q, n_q;

  assign en        = ~vld_q[LAST] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[LAST];
  assign S         = s_out;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign So        = so_q;
  assign Z         = z_q;
  assign N         = n_q;

  always_comb begin
    a_i[0]  = A;
    bx_i[0] = B ^ {WIDTH{D}};
    s_i[0]  = '0;
    c_i[0]  = Cin | D;
    d_i[0]  = D;
    si_i[0] = Si;
    v_i[0]  = in_valid;
`ifdef ADDSUB_SAT_EN
    sat_i[0] = Sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_i[k]  = a_q[k-1];
      bx_i[k] = bx_q[k-1];
      s_i[k]  = s_q[k-1];
      c_i[k]  = c_q[k-1];
      d_i[k]  = d_q[k-1];
      si_i[k] = si_q[k-1];
      v_i[k]  = vld_q[k-1];
`ifdef ADDSUB_SAT_EN
      sat_i[k] = sat_q[k-1];
`endif
    end

    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_i[k][k*SEG +: SEG]} + {1'b0, bx_i[k][k*SEG +: SEG]} + SW'(c_i[k]);
      s_nx[k] = s_i[k];
      s_nx[k][k*SEG +: SEG] = part[SEG-1:0];
      c_nx[k] = part[SEG];
    end

    // Carry into the MSB falls out of the MSB sum bit and its two operand bits.
    cmsb  = a_i[LAST][WIDTH-1] ^ bx_i[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1];
    ovf   = cmsb ^ c_nx[LAST];
    so_nx = si_i[LAST] | (d_i[LAST] & ~c_nx[LAST]);
    res   = s_nx[LAST];
`ifdef ADDSUB_SAT_EN
    if (sat_i[LAST]) begin
      if (si_i[LAST] & ovf)
        res = a_i[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else if (~si_i[LAST] & ~d_i[LAST] & c_nx[LAST])
        res = '1;
      else if (~si_i[LAST] & d_i[LAST] & ~c_nx[LAST])
        res = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        d_q[k]   <= 1'b0;
        si_q[k]  <= 1'b0;
`ifdef ADDSUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      s_out  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      so_q   <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_i[k];
        a_q[k]   <= a_i[k];
        bx_q[k]  <= bx_i[k];
        s_q[k]   <= s_nx[k];
        c_q[k]   <= c_nx[k];
        d_q[k]   <= d_i[k];
        si_q[k]  <= si_i[k];
`ifdef ADDSUB_SAT_EN
        sat_q[k] <= sat_i[k];
`endif
      end
      s_out  <= res;
      cout_q <= c_nx[LAST];
      v_q    <= ovf;
      so_q   <= so_nx;
      z_q    <= (res == '0);
      n_q    <= res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=32, STAGES=4, default build without saturation).
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0, B = '0;
  logic        D = 1'b0, Cin = 1'b0, Si = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] S;
  logic        Cout, V, So, Z, N;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        so;
    logic        z;
    logic        n;
  } res_t;

  res_t exp_q[$];
  res_t cur_exp = '0;
  res_t snap = '0;
  logic held = 1'b0;
  logic rnd_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .D(D), .Cin(Cin), .Si(Si),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .So(So), .Z(Z), .N(N)
  );

  function automatic res_t mk(input logic [31:0] s, input logic c, v, so, z, n);
    mk = {s, c, v, so, z, n};
  endfunction

  function automatic res_t model(input logic [31:0] a, b, input logic d, cin, si);
    logic [32:0] t;
    logic [31:0] bx;
    res_t r;
    bx   = d ? ~b : b;
    t    = {1'b0, a} + {1'b0, bx} + {32'd0, (cin | d)};
    r.s  = t[31:0];
    r.c  = t[32];
    r.v  = (a[31] == bx[31]) && (t[31] != a[31]);
    r.so = si | (d & ~t[32]);
    r.z  = (t[31:0] == 32'd0);
    r.n  = t[31];
    return r;
  endfunction

  // expected result is queued at the moment the transfer is committed
  always @(negedge clk)
    if (!rst && in_valid && in_ready) exp_q.push_back(cur_exp);

  always @(negedge clk) begin
    res_t got;
    res_t e;
    got = {S, Cout, V, So, Z, N};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!out_valid || got !== snap) begin
          errors++;
          $display("FAIL hold: got valid=%0b res=%h required valid=1 res=%h", out_valid, got, snap);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got S=%h with no result outstanding", S);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result: got S=%h C=%0b V=%0b So=%0b Z=%0b N=%0b required S=%h C=%0b V=%0b So=%0b Z=%0b N=%0b",
                     S, Cout, V, So, Z, N, e.s, e.c, e.v, e.so, e.z, e.n);
          end
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %0b required 0", in_ready);
        end
        snap = got;
        held = 1'b1;
      end else begin
        held = 1'b0;
      end
    end
  end

  // called just after a rising edge; returns just after the edge that took the op
  task automatic send(input logic [31:0] a, b, input logic d, cin, si, input res_t e);
    int   n;
    logic acc;
    in_valid = 1'b1;
    A = a; B = b; D = d; Cin = cin; Si = si;
    cur_exp = e;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required 1", n);
    end
    in_valid = 1'b0;
    A = 'x; B = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rd, rc, rs;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, S, Cout, V, So, Z, N} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b S=%h flags=%b required all zero",
               out_valid, S, {Cout, V, So, Z, N});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;

    // directed: a, b, d, cin, si -> s, c, v, so, z, n
    send(32'd5,         32'd3,         1'b0, 1'b0, 1'b0, mk(32'd8,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'd3,         32'd5,         1'b1, 1'b0, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    send(32'hFFFFFFFF, 32'd1,         1'b0, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    send(32'h7FFFFFFF, 32'd1,         1'b0, 1'b0, 1'b1, mk(32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    send(32'd5,         32'd5,         1'b1, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    send(32'h0000FFFF, 32'd1,         1'b0, 1'b0, 1'b0, mk(32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h80000000, 32'd1,         1'b1, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    send(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b0, mk(32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h000000FF, 32'd0,         1'b0, 1'b1, 1'b0, mk(32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'd0,         32'd1,         1'b1, 1'b0, 1'b0, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, mk(32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    send(32'd10,        32'd3,         1'b1, 1'b1, 1'b0, mk(32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 1'b0, mk(32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    // eight back-to-back ops with a three-cycle consumer stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 32'h11111111 * i;
          rb = 32'h01010101 * (i + 3);
          rd = i[0];
          send(ra, rb, rd, 1'b0, i[1], model(ra, rb, rd, 1'b0, i[1]));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // random valid/ready traffic
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          ra = $urandom;
          rb = $urandom;
          rd = 1'($urandom_range(0, 1));
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rd, rc, rs, model(ra, rb, rd, rc, rs));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with ops in flight: the oldest has just reached the output
    for (int i = 0; i < 4; i++)
      send(32'h100 + i, 32'd1, 1'b0, 1'b0, 1'b0, model(32'h100 + i, 32'd1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || S !== 32'd0) begin
      errors++;
      $display("FAIL reset_inflight: got valid=%0b S=%h required valid=0 S=0", out_valid, S);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    send(32'd40, 32'd2, 1'b0, 1'b0, 1'b0, mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
